// File: rtl/sbox_array.sv
`default_nettype none
// ============================================================================
// Module   : sbox_array
// Brief    : LANES-wide two-stage AES S-box pipeline with a valid/ready handshake.
//            Defining SBOX_ARRAY_INV_EN adds the inverse table and per-beat in_inv.
// Revision : 1.0  initial release
// ============================================================================
module sbox_array #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);

    // Byte 0 of each table sits in the most significant byte.
    localparam logic [2047:0] c_FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SBOX_ARRAY_INV_EN
    localparam logic [2047:0] c_INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    logic inv1_q;
    logic inv1_d;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
`endif

    logic               v1_q;
    logic               v1_d;
    logic               v2_q;
    logic               v2_d;
    logic [8*LANES-1:0] data1_q;
    logic [8*LANES-1:0] data1_d;
    logic [8*LANES-1:0] data2_q;
    logic [8*LANES-1:0] data2_d;
    logic [8*LANES-1:0] w_sub;
    logic               w_ready1;
    logic               w_ready2;

    assign w_ready2 = !v2_q || out_ready;
    assign w_ready1 = !v1_q || w_ready2;

    // Lookup sits between S1 and S2; bit offset of byte b is 8*(255-b) = {~b,3'b0}.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [10:0] w_idx;
        assign w_idx = {~data1_q[8*i +: 8], 3'b000};
`ifdef SBOX_ARRAY_INV_EN
        assign w_sub[8*i +: 8] = inv1_q ? c_INV_TABLE[w_idx +: 8] : c_FWD_TABLE[w_idx +: 8];
`else
        assign w_sub[8*i +: 8] = c_FWD_TABLE[w_idx +: 8];
`endif
    end

    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        data1_d = data1_q;
        data2_d = data2_q;
`ifdef SBOX_ARRAY_INV_EN
        inv1_d  = inv1_q;
`endif
        if (w_ready1) begin
            v1_d = in_valid;
            if (in_valid) begin
                data1_d = in_data;
`ifdef SBOX_ARRAY_INV_EN
                inv1_d  = in_inv;
`endif
            end
        end
        if (w_ready2) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = w_sub;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            data2_q <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            data2_q <= data2_d;
        end
    end

    // S1 payload is qualified by v1_q, so it carries no reset.
    always_ff @(posedge clk) begin
        data1_q <= data1_d;
`ifdef SBOX_ARRAY_INV_EN
        inv1_q  <= inv1_d;
`endif
    end

    assign in_ready  = w_ready1;
    assign out_valid = v2_q;
    assign out_data  = data2_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbox_array
// Brief    : Directed self-checking bench for sbox_array (LANES=4 and LANES=16).
// Revision : 1.0  initial release
// ============================================================================
module tb_sbox_array;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid4, in_ready4, in_inv4, out_valid4, out_ready4;
    logic [31:0]  in_data4, out_data4;
    logic         in_valid16, in_ready16, in_inv16, out_valid16, out_ready16;
    logic [127:0] in_data16, out_data16;

    sbox_array #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_inv(in_inv4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
    );

    sbox_array #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16), .in_inv(in_inv16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16)
    );

`ifdef SBOX_ARRAY_INV_EN
    localparam logic        c_INV_EN  = 1'b1;
    localparam logic [31:0] c_EXP_INV = 32'h00010253;
    localparam logic [31:0] c_EXP_Z   = 32'h52525252;
`else
    localparam logic        c_INV_EN  = 1'b0;
    localparam logic [31:0] c_EXP_INV = 32'hfb10f555;
    localparam logic [31:0] c_EXP_Z   = 32'h63636363;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  got4[$], exp4[$];
    logic [127:0] got16[$], exp16[$];
    int           t16[$];
    logic [7:0]   fwd_tab[256];
    logic [7:0]   inv_tab[256];

    // Transfers are decided at the next rising edge; outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid4 && out_ready4) got4.push_back(out_data4);
        if (!rst && out_valid16 && out_ready16) begin
            got16.push_back(out_data16);
            t16.push_back(cyc);
        end
    end

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    // Reference S-box from GF(2^8) inversion plus the AES affine transform.
    function automatic logic [7:0] sbox_ref(input logic [7:0] a);
        logic [7:0] iv;
        iv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(a, 8'(b)) == 8'h01) iv = 8'(b);
        return iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
    endfunction

    task automatic send4(input logic [31:0] d, input logic inv, input logic [31:0] e);
        bit acc = 1'b0;
        int n   = 0;
        in_valid4 = 1'b1;
        in_data4  = d;
        in_inv4   = inv;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready4;
            @(posedge clk);
            #1;
            n++;
        end
        check_vec("send4_accept", 128'(acc), 128'd1);
        if (acc) exp4.push_back(e);
    endtask

    task automatic drain4(input string tag);
        int n = 0;
        while (got4.size() < exp4.size() && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_vec({tag, "_count"}, 128'(got4.size()), 128'(exp4.size()));
        for (int i = 0; i < exp4.size() && i < got4.size(); i++)
            check_vec($sformatf("%s[%0d]", tag, i), 128'(got4[i]), 128'(exp4[i]));
        got4.delete();
        exp4.delete();
    endtask

    task automatic send16(input logic [127:0] d, input logic inv, input logic [127:0] e,
                          input bit rnd);
        bit acc = 1'b0;
        int n   = 0;
        in_valid16 = 1'b1;
        in_data16  = d;
        in_inv16   = inv;
        while (!acc && n < 50) begin
            if (rnd) out_ready16 = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready16;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_vec("send16_accept", 128'(acc), 128'd1);
        if (acc) exp16.push_back(e);
    endtask

    task automatic drain16(input string tag, input bit chk_tput);
        int n = 0;
        out_ready16 = 1'b1;
        while (got16.size() < exp16.size() && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_vec({tag, "_count"}, 128'(got16.size()), 128'(exp16.size()));
        for (int i = 0; i < exp16.size() && i < got16.size(); i++)
            check_vec($sformatf("%s[%0d]", tag, i), got16[i], exp16[i]);
        if (chk_tput && t16.size() == 16)
            check_vec({tag, "_tput"}, 128'(t16[15] - t16[0]), 128'd15);
        got16.delete();
        exp16.delete();
        t16.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    logic [127:0] d16, e16;
    logic         inv_b;

    initial begin
        for (int a = 0; a < 256; a++) begin
            fwd_tab[a]          = sbox_ref(8'(a));
            inv_tab[fwd_tab[a]] = 8'(a);
        end

        rst = 1'b1;
        in_valid4 = 1'b0; in_data4 = '0; in_inv4 = 1'b0; out_ready4 = 1'b1;
        in_valid16 = 1'b0; in_data16 = '0; in_inv16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_vec("rst_out_valid", 128'(out_valid4), 128'd0);
        check_vec("rst_out_data", 128'(out_data4), 128'd0);
        rst = 1'b0;
        #1;
        check_vec("rst_in_ready", 128'(in_ready4), 128'd1);
        @(posedge clk);
        #1;

        // Single beat: latency from the accept edge
        send4(32'h00010253, 1'b0, 32'h637c77ed);
        in_valid4 = 1'b0;
        check_vec("lat_edge1_valid", 128'(out_valid4), 128'd0);
        @(posedge clk);
        #1;
        check_vec("lat_edge2_valid", 128'(out_valid4), 128'd1);
        check_vec("lat_edge2_data", 128'(out_data4), 128'h637c77ed);
        drain4("basic");

        // Back-to-back beats of mixed mode
        send4(32'h00010253, 1'b0, 32'h637c77ed);
        send4(32'h637c77ed, 1'b1, c_EXP_INV);
        send4(32'h00000000, 1'b1, c_EXP_Z);
        send4(32'hffffffff, 1'b0, 32'h16161616);
        in_valid4 = 1'b0;
        drain4("mixed");

        // Backpressure: two beats fill the pipe, the third waits
        out_ready4 = 1'b0;
        in_valid4  = 1'b1; in_inv4 = 1'b0; in_data4 = 32'h00112233;
        @(negedge clk);
        check_vec("bp_rdy_a", 128'(in_ready4), 128'd1);
        @(posedge clk);
        #1;
        exp4.push_back(32'h638293c3);
        in_data4 = 32'h44556677;
        @(negedge clk);
        check_vec("bp_rdy_b", 128'(in_ready4), 128'd1);
        @(posedge clk);
        #1;
        exp4.push_back(32'h1bfc33f5);
        in_data4 = 32'h8899aabb;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_vec("bp_full_rdy", 128'(in_ready4), 128'd0);
            check_vec("bp_hold_valid", 128'(out_valid4), 128'd1);
            check_vec("bp_hold_data", 128'(out_data4), 128'h638293c3);
            @(posedge clk);
            #1;
        end
        out_ready4 = 1'b1;
        #1;
        check_vec("bp_release_rdy", 128'(in_ready4), 128'd1);
        @(posedge clk);
        #1;
        exp4.push_back(32'hc4eeacea);
        in_valid4 = 1'b0;
        drain4("bp");

        // Asynchronous reset with two beats in flight
        out_ready4 = 1'b0;
        in_valid4  = 1'b1; in_data4 = 32'h01020304;
        @(posedge clk);
        #1;
        in_data4 = 32'h05060708;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        check_vec("pre_rst_valid", 128'(out_valid4), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check_vec("async_rst_valid", 128'(out_valid4), 128'd0);
        check_vec("async_rst_data", 128'(out_data4), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got4.delete();
        exp4.delete();
        out_ready4 = 1'b1;
        send4(32'hffffffff, 1'b0, 32'h16161616);
        in_valid4 = 1'b0;
        drain4("post_rst");

        // 16 lanes: forward sweep of all byte values at full rate
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                d16[8*j +: 8] = 8'(16 * k + j);
                e16[8*j +: 8] = fwd_tab[16 * k + j];
            end
            send16(d16, 1'b0, e16, 1'b0);
        end
        in_valid16 = 1'b0;
        drain16("sweep_fwd", 1'b1);

        // 16 lanes: sweep again with random backpressure (inverse mode when built in)
        inv_b = c_INV_EN;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                d16[8*j +: 8] = 8'(16 * k + j);
                e16[8*j +: 8] = inv_b ? inv_tab[16 * k + j] : fwd_tab[16 * k + j];
            end
            send16(d16, inv_b, e16, 1'b1);
        end
        in_valid16 = 1'b0;
        drain16("sweep_rnd", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
